// File: rtl/toy_writeback.sv
// rtl/toy_writeback.sv - round-robin result writeback and commit stage.
// Defining TOY_WB_CUST_EN adds the cust channel (5 channels); otherwise there are 4.
package toy_pack;
  localparam int INST_IDX_WIDTH = 6;
  localparam int REG_WIDTH      = 32;
endpackage

module toy_writeback
  import toy_pack::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      lsu_res_vld,
  output logic                      lsu_res_rdy,
  input  logic [INST_IDX_WIDTH-1:0] lsu_res_idx,
  input  logic [4:0]                lsu_res_rd,
  input  logic                      lsu_res_rd_en,
  input  logic [REG_WIDTH-1:0]      lsu_res_val,
  input  logic                      alu_res_vld,
  output logic                      alu_res_rdy,
  input  logic [INST_IDX_WIDTH-1:0] alu_res_idx,
  input  logic [4:0]                alu_res_rd,
  input  logic                      alu_res_rd_en,
  input  logic [REG_WIDTH-1:0]      alu_res_val,
  input  logic                      mext_res_vld,
  output logic                      mext_res_rdy,
  input  logic [INST_IDX_WIDTH-1:0] mext_res_idx,
  input  logic [4:0]                mext_res_rd,
  input  logic                      mext_res_rd_en,
  input  logic [REG_WIDTH-1:0]      mext_res_val,
  input  logic                      csr_res_vld,
  output logic                      csr_res_rdy,
  input  logic [INST_IDX_WIDTH-1:0] csr_res_idx,
  input  logic [4:0]                csr_res_rd,
  input  logic                      csr_res_rd_en,
  input  logic [REG_WIDTH-1:0]      csr_res_val,
`ifdef TOY_WB_CUST_EN
  input  logic                      cust_res_vld,
  output logic                      cust_res_rdy,
  input  logic [INST_IDX_WIDTH-1:0] cust_res_idx,
  input  logic [4:0]                cust_res_rd,
  input  logic                      cust_res_rd_en,
  input  logic [REG_WIDTH-1:0]      cust_res_val,
`endif
  output logic                      reg_wr_en,
  output logic [4:0]                reg_wr_addr,
  output logic [REG_WIDTH-1:0]      reg_wr_data,
  output logic                      commit_vld,
  input  logic                      commit_rdy,
  output logic [INST_IDX_WIDTH-1:0] commit_idx,
  output logic [31:0]               wb_cnt
);

`ifdef TOY_WB_CUST_EN
  localparam int N = 5;
`else
  localparam int N = 4;
`endif

  logic [N-1:0]              vld;
  logic [N-1:0]              rdy;
  logic [INST_IDX_WIDTH-1:0] ch_idx   [N];
  logic [4:0]                ch_rd    [N];
  logic                      ch_rd_en [N];
  logic [REG_WIDTH-1:0]      ch_val   [N];

  logic [2:0]                rr_ptr;
  logic                      out_vld;
  logic [INST_IDX_WIDTH-1:0] out_idx;
  logic [4:0]                out_rd;
  logic                      out_rd_en;
  logic [REG_WIDTH-1:0]      out_val;

  logic                      gnt_any;
  logic [2:0]                gnt_ch;
  logic [2:0]                nxt_ptr;
  logic                      drain;

  assign vld[0] = lsu_res_vld;
  assign ch_idx[0] = lsu_res_idx;
  assign ch_rd[0] = lsu_res_rd;
  assign ch_rd_en[0] = lsu_res_rd_en;
  assign ch_val[0] = lsu_res_val;
  assign vld[1] = alu_res_vld;
  assign ch_idx[1] = alu_res_idx;
  assign ch_rd[1] = alu_res_rd;
  assign ch_rd_en[1] = alu_res_rd_en;
  assign ch_val[1] = alu_res_val;
  assign vld[2] = mext_res_vld;
  assign ch_idx[2] = mext_res_idx;
  assign ch_rd[2] = mext_res_rd;
  assign ch_rd_en[2] = mext_res_rd_en;
  assign ch_val[2] = mext_res_val;
  assign vld[3] = csr_res_vld;
  assign ch_idx[3] = csr_res_idx;
  assign ch_rd[3] = csr_res_rd;
  assign ch_rd_en[3] = csr_res_rd_en;
  assign ch_val[3] = csr_res_val;
  assign lsu_res_rdy = rdy[0];
  assign alu_res_rdy = rdy[1];
  assign mext_res_rdy = rdy[2];
  assign csr_res_rdy = rdy[3];
`ifdef TOY_WB_CUST_EN
  assign vld[4] = cust_res_vld;
  assign ch_idx[4] = cust_res_idx;
  assign ch_rd[4] = cust_res_rd;
  assign ch_rd_en[4] = cust_res_rd_en;
  assign ch_val[4] = cust_res_val;
  assign cust_res_rdy = rdy[4];
`endif

  assign drain = out_vld & commit_rdy;

  // Scan channels starting at rr_ptr; a full stage only accepts while it drains.
  always_comb begin
    int ch;
    gnt_any = 1'b0;
    gnt_ch  = 3'd0;
    rdy     = '0;
    ch      = 0;
    if (!rst && (!out_vld || commit_rdy)) begin
      for (int i = 0; i < N; i++) begin
        ch = int'(rr_ptr) + i;
        if (ch >= N) ch = ch - N;
        if (!gnt_any && vld[ch]) begin
          gnt_any = 1'b1;
          gnt_ch  = ch[2:0];
        end
      end
    end
    if (gnt_any) rdy[gnt_ch] = 1'b1;
  end

  assign nxt_ptr = (gnt_ch == 3'(N - 1)) ? 3'd0 : gnt_ch + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= 3'd0;
      out_vld   <= 1'b0;
      out_idx   <= '0;
      out_rd    <= '0;
      out_rd_en <= 1'b0;
      out_val   <= '0;
      wb_cnt    <= 32'd0;
    end else begin
      if (gnt_any) begin
        rr_ptr    <= nxt_ptr;
        out_vld   <= 1'b1;
        out_idx   <= ch_idx[gnt_ch];
        out_rd    <= ch_rd[gnt_ch];
        out_rd_en <= ch_rd_en[gnt_ch];
        out_val   <= ch_val[gnt_ch];
      end else if (drain) begin
        out_vld <= 1'b0;
      end
      if (drain) wb_cnt <= wb_cnt + 32'd1;
    end
  end

  assign commit_vld  = out_vld;
  assign commit_idx  = out_idx;
  // x0 results commit but never touch the register file.
  assign reg_wr_en   = drain & out_rd_en & (out_rd != 5'd0);
  assign reg_wr_addr = reg_wr_en ? out_rd : 5'd0;
  assign reg_wr_data = reg_wr_en ? out_val : '0;

endmodule

// File: tb/tb_toy_writeback.sv
// tb/tb_toy_writeback.sv - scoreboard bench for toy_writeback.
module tb_toy_writeback;
  import toy_pack::*;

`ifdef TOY_WB_CUST_EN
  localparam int NCH = 5;
`else
  localparam int NCH = 4;
`endif

  typedef struct packed {
    logic [INST_IDX_WIDTH-1:0] idx;
    logic [4:0]                rd;
    logic                      rd_en;
    logic [REG_WIDTH-1:0]      val;
  } item_t;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NCH-1:0]            vld = '0;
  logic [NCH-1:0]            rdy;
  item_t                     cur [NCH];
  logic                      reg_wr_en;
  logic [4:0]                reg_wr_addr;
  logic [REG_WIDTH-1:0]      reg_wr_data;
  logic                      commit_vld;
  logic                      commit_rdy = 1'b1;
  logic [INST_IDX_WIDTH-1:0] commit_idx;
  logic [31:0]               wb_cnt;

  item_t src_mem [NCH][16];
  int    src_rd  [NCH];
  int    src_wr  [NCH];
  item_t sb [$];
  int    gnt_log [$];
  int    m_ptr = 0;
  logic [31:0] m_cnt = 32'd0;
  logic  m_gnt_any = 1'b0;
  int    m_gnt_ch = 0;
  int    nidx = 1;
  int    checks = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  toy_writeback dut (
    .clk(clk), .rst(rst),
    .lsu_res_vld(vld[0]), .lsu_res_rdy(rdy[0]), .lsu_res_idx(cur[0].idx),
    .lsu_res_rd(cur[0].rd), .lsu_res_rd_en(cur[0].rd_en), .lsu_res_val(cur[0].val),
    .alu_res_vld(vld[1]), .alu_res_rdy(rdy[1]), .alu_res_idx(cur[1].idx),
    .alu_res_rd(cur[1].rd), .alu_res_rd_en(cur[1].rd_en), .alu_res_val(cur[1].val),
    .mext_res_vld(vld[2]), .mext_res_rdy(rdy[2]), .mext_res_idx(cur[2].idx),
    .mext_res_rd(cur[2].rd), .mext_res_rd_en(cur[2].rd_en), .mext_res_val(cur[2].val),
    .csr_res_vld(vld[3]), .csr_res_rdy(rdy[3]), .csr_res_idx(cur[3].idx),
    .csr_res_rd(cur[3].rd), .csr_res_rd_en(cur[3].rd_en), .csr_res_val(cur[3].val),
`ifdef TOY_WB_CUST_EN
    .cust_res_vld(vld[4]), .cust_res_rdy(rdy[4]), .cust_res_idx(cur[4].idx),
    .cust_res_rd(cur[4].rd), .cust_res_rd_en(cur[4].rd_en), .cust_res_val(cur[4].val),
`endif
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .commit_vld(commit_vld), .commit_rdy(commit_rdy), .commit_idx(commit_idx),
    .wb_cnt(wb_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: predict grants, keep the expected stage contents and count.
  always @(negedge clk) begin
    logic           full;
    logic           any;
    logic           wr;
    int             gch;
    int             ch;
    logic [NCH-1:0] exp_rdy;
    item_t          e;
    any = 1'b0;
    gch = 0;
    exp_rdy = '0;
    if (rst) begin
      sb.delete();
      m_ptr = 0;
      m_cnt = 32'd0;
      check_eq("rst_rdy", 64'(rdy), 64'd0);
      check_eq("rst_commit_vld", 64'(commit_vld), 64'd0);
      check_eq("rst_reg_wr_en", 64'(reg_wr_en), 64'd0);
    end else begin
      full = (sb.size() != 0);
      check_eq("commit_vld", 64'(commit_vld), 64'(full));
      check_eq("wb_cnt", 64'(wb_cnt), 64'(m_cnt));
      check_eq("rr_ptr", 64'(dut.rr_ptr), 64'(m_ptr));
      if (!full || commit_rdy) begin
        for (int i = 0; i < NCH; i++) begin
          ch = (m_ptr + i) % NCH;
          if (!any && vld[ch]) begin
            any = 1'b1;
            gch = ch;
          end
        end
      end
      if (any) exp_rdy[gch] = 1'b1;
      check_eq("res_rdy", 64'(rdy), 64'(exp_rdy));
      if (full) begin
        e  = sb[0];
        wr = commit_rdy && e.rd_en && (e.rd != 5'd0);
        check_eq("commit_idx", 64'(commit_idx), 64'(e.idx));
        check_eq("reg_wr_en", 64'(reg_wr_en), 64'(wr));
        check_eq("reg_wr_addr", 64'(reg_wr_addr), wr ? 64'(e.rd) : 64'd0);
        check_eq("reg_wr_data", 64'(reg_wr_data), wr ? 64'(e.val) : 64'd0);
        if (commit_rdy) begin
          void'(sb.pop_front());
          m_cnt = m_cnt + 32'd1;
        end
      end else begin
        check_eq("idle_reg_wr_en", 64'(reg_wr_en), 64'd0);
        check_eq("idle_reg_wr_addr", 64'(reg_wr_addr), 64'd0);
      end
      if (any) begin
        sb.push_back(cur[gch]);
        m_ptr = (gch + 1) % NCH;
        gnt_log.push_back(gch);
      end
    end
    m_gnt_any = any;
    m_gnt_ch  = gch;
  end

  // Sources: present the head item until the model says it was taken.
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (m_gnt_any && m_gnt_ch == c) src_rd[c]++;
      vld[c] = (src_rd[c] < src_wr[c]);
      cur[c] = vld[c] ? src_mem[c][src_rd[c]] : '0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input int c, input logic [4:0] rd, input logic rd_en, input logic [REG_WIDTH-1:0] val);
    item_t it;
    it.idx   = INST_IDX_WIDTH'(nidx);
    it.rd    = rd;
    it.rd_en = rd_en;
    it.val   = val;
    nidx++;
    src_mem[c][src_wr[c]] = it;
    src_wr[c]++;
  endtask

  task automatic wait_idle();
    bit busy;
    int n;
    n = 0;
    busy = 1'b1;
    while (busy && n < 200) begin
      cyc(1);
      n++;
      busy = (sb.size() != 0);
      for (int c = 0; c < NCH; c++) if (src_rd[c] < src_wr[c]) busy = 1'b1;
    end
    check_eq("idle_timeout", 64'(busy), 64'd0);
    cyc(2);
    for (int c = 0; c < NCH; c++) begin
      src_rd[c] = 0;
      src_wr[c] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [INST_IDX_WIDTH-1:0] held;
    for (int c = 0; c < NCH; c++) begin
      src_rd[c] = 0;
      src_wr[c] = 0;
      cur[c] = '0;
    end
    cyc(3);
    check_eq("reset_wb_cnt", 64'(wb_cnt), 64'd0);
    check_eq("reset_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    rst = 1'b0;
    cyc(1);

    // Single ALU result.
    push(1, 5'd5, 1'b1, 32'h1234);
    wait_idle();
    check_eq("single_wb_cnt", 64'(wb_cnt), 64'd1);

    // Every channel loaded at once after reset: strict rotation.
    do_reset();
    gnt_log.delete();
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < NCH; c++) push(c, 5'(c + 1 + 8 * k), 1'b1, 32'(32'hA000 + 16 * c + k));
    wait_idle();
    check_eq("rotation_len", 64'(gnt_log.size()), 64'(3 * NCH));
    for (int i = 0; i < gnt_log.size(); i++)
      check_eq("rotation_order", 64'(gnt_log[i]), 64'(i % NCH));

    // Backpressure: stage holds, then drain and reload in one cycle.
    commit_rdy = 1'b0;
    push(0, 5'd10, 1'b1, 32'hBEEF0001);
    push(0, 5'd11, 1'b1, 32'hBEEF0002);
    push(1, 5'd12, 1'b1, 32'hBEEF0003);
    cyc(2);
    held = commit_idx;
    cyc(3);
    check_eq("stall_idx_stable", 64'(commit_idx), 64'(held));
    check_eq("stall_commit_vld", 64'(commit_vld), 64'd1);
    commit_rdy = 1'b1;
    wait_idle();

    // x0 destination, write disabled, and top register.
    push(2, 5'd0, 1'b1, 32'hDEAD0000);
    push(3, 5'd7, 1'b0, 32'hCAFE0000);
    push(0, 5'd31, 1'b1, 32'hFFFF_FFFF);
    wait_idle();

    // Count wrap from all ones.
    force dut.wb_cnt = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.wb_cnt;
    cyc(1);
    check_eq("preset_wb_cnt", 64'(wb_cnt), 64'hFFFF_FFFF);
    push(1, 5'd3, 1'b1, 32'h5);
    wait_idle();
    check_eq("wrap_wb_cnt", 64'(wb_cnt), 64'd0);

    // Reset with the stage full discards the entry.
    commit_rdy = 1'b0;
    push(1, 5'd9, 1'b1, 32'h99);
    cyc(3);
    check_eq("pre_rst_commit_vld", 64'(commit_vld), 64'd1);
    check_eq("pre_rst_ptr_nonzero", 64'(dut.rr_ptr != 3'd0), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_async_commit_vld", 64'(commit_vld), 64'd0);
    check_eq("rst_async_wb_cnt", 64'(wb_cnt), 64'd0);
    cyc(2);
    rst = 1'b0;
    commit_rdy = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      src_rd[c] = 0;
      src_wr[c] = 0;
    end
    cyc(1);
    check_eq("post_rst_ptr", 64'(dut.rr_ptr), 64'd0);
    check_eq("post_rst_commit_vld", 64'(commit_vld), 64'd0);
    push(3, 5'd4, 1'b1, 32'h44);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/toy_writeback.md
TOY_WRITEBACK -- requirements
Module: toy_writeback

Interface
REQ-001 SHALL use toy_pack constants: INST_IDX_WIDTH (package default) = instruction index width; REG_WIDTH (package default) = register data width.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clk in 1 = sole clock; rst in 1 = asynchronous active-high reset.
REQ-003 SHALL have, per source <u> in {lsu, alu, mext, csr, cust} (channel order 0..4), the following ports:
- <u>_res_vld  in  1  result valid
- <u>_res_rdy  out  1  result accepted
- <u>_res_idx  in  INST_IDX_WIDTH  instruction index
- <u>_res_rd  in  5  destination register
- <u>_res_rd_en  in  1  destination write required
- <u>_res_val  in  REG_WIDTH  result value
REQ-004 SHALL have the register-file write port:
- reg_wr_en  out  1  write strobe
- reg_wr_addr  out  5  write address
- reg_wr_data  out  REG_WIDTH  write data
REQ-005 SHALL have the commit port:
- commit_vld  out  1  instruction complete
- commit_rdy  in  1  commit consumer ready
- commit_idx  out  INST_IDX_WIDTH  completed index
REQ-006 SHALL have: wb_cnt  out  32  count of completed instructions.

Function
REQ-007 SHALL arbitrate round-robin among asserted <u>_res_vld using a 3-bit pointer rr_ptr that names the highest-priority channel; priority descends cyclically from rr_ptr.
REQ-008 SHALL grant at most one channel per cycle, and only when the output stage is empty or is draining this cycle (out_vld=0 or commit_rdy=1).
REQ-009 SHALL drive <u>_res_rdy=1 only for the granted channel; rdy depends combinationally on the vld inputs, so sources SHALL NOT make vld depend on rdy.
REQ-010 SHALL, on a grant to channel k, set rr_ptr to (k+1) mod N at the next edge; rr_ptr SHALL hold when there is no grant.
REQ-011 SHALL capture the granted idx/rd/rd_en/val into a single output register (out_vld set) at the grant edge; latency is one cycle (accept in cycle N, commit_vld in cycle N+1).
REQ-012 SHALL drive commit_vld=out_vld and commit_idx=out_idx; the stage SHALL hold stable while commit_vld=1 and commit_rdy=0.
REQ-013 SHALL drain the stage when commit_vld=1 and commit_rdy=1; a simultaneous drain and new grant SHALL reload the stage without a bubble.
REQ-014 SHALL assert reg_wr_en = commit_vld & commit_rdy & out_rd_en & (out_rd != 0), with reg_wr_addr=out_rd and reg_wr_data=out_val; a result to x0 SHALL commit without a write.
REQ-015 SHALL increment wb_cnt by 1 on each drain, wrapping from 0xFFFFFFFF to 0.
REQ-016 SHALL hold reg_wr_addr and reg_wr_data at 0 whenever reg_wr_en=0.

Reset
REQ-017 SHALL, while rst=1 (asynchronously): out_vld=0, rr_ptr=0, wb_cnt=0, all stage fields=0.
REQ-018 SHALL, during reset, hold all <u>_res_rdy, commit_vld and reg_wr_en at 0; an in-flight stage entry SHALL be discarded on reset assertion.

Configuration
REQ-019 SHALL, with TOY_WB_CUST_EN defined, include the cust channel and use N=5.
REQ-020 SHALL, with TOY_WB_CUST_EN undefined, omit the cust_res_* ports and use N=4, with rr_ptr wrapping from 3 to 0.

Verification
REQ-021 Single source: alu_res_vld=1, rd=5, val=0x1234, commit_rdy=1 -> alu_res_rdy=1 in cycle 0; cycle 1: commit_vld=1, reg_wr_en=1, addr=5, data=0x1234; wb_cnt=1.
REQ-022 All sources valid continuously after reset, commit_rdy=1 -> grant order lsu, alu, mext, csr, cust, lsu, ... at one per cycle (4-way order when the macro is off).
REQ-023 commit_rdy=0 for 3 cycles with stage full -> no rdy asserted, commit_idx stable; on commit_rdy=1 -> drain plus new grant in the same cycle.
REQ-024 Result with rd=0, rd_en=1 -> commit_vld=1, reg_wr_en=0, wb_cnt increments.
REQ-025 wb_cnt preset by forcing 0xFFFFFFFF, then one drain -> wb_cnt=0; rst asserted with stage full -> commit_vld=0 immediately, rr_ptr=0 after release.
